// File: rtl/pipe_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_phy_pkg
// Description : Shared types and constants for the PIPE PHY command responder.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_phy_pkg;

  // Responder FSM states
  typedef enum logic [2:0] {
    RESET_WAIT  = 3'd0,
    IDLE        = 3'd1,
    PD_CHANGE   = 3'd2,
    RATE_CHANGE = 3'd3,
    RX_DETECT   = 3'd4,
    DET_RELEASE = 3'd5
  } phy_state_t;

  // PIPE power states
  localparam logic [3:0] P0  = 4'h0;
  localparam logic [3:0] P0s = 4'h1;
  localparam logic [3:0] P1  = 4'h2;
  localparam logic [3:0] P2  = 4'h3;

  // RxStatus code reported for a lane whose far-end receiver was detected
  localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

  // Width of the latency counter
  localparam int CNT_W = 16;

endpackage : pipe_phy_pkg
`default_nettype wire

// File: rtl/pipe_phy_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_phy_delay_cnt
// Description : 16-bit load/decrement latency counter. Decrements down to 1
//               and holds there; flags the last two counts for the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_phy_delay_cnt
  import pipe_phy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_one,
  output logic             at_two
);

  // Load has priority; decrement stops at 1 so the counter never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count > CNT_W'(1))) begin
      count <= count - CNT_W'(1);
    end
  end

  assign at_one = (count == CNT_W'(1));
  assign at_two = (count == CNT_W'(2));

endmodule : pipe_phy_delay_cnt
`default_nettype wire

// File: rtl/pipe_phy_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_phy_cmd_responder
// Description : Behavioural PIPE PHY responder. Answers MAC PowerDown, Rate
//               and receiver-detect requests with latency-accurate PhyStatus
//               pulses, and tracks the power state and rate in effect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_phy_cmd_responder
  import pipe_phy_pkg::*;
#(
  parameter int pipe_num_of_lanes = 16,
  parameter int PD_LATENCY        = 8,
  parameter int RATE_LATENCY      = 16,
  parameter int DETECT_LATENCY    = 12,
  parameter int RESET_LATENCY     = 4
) (
  input  logic                           PCLK,
  input  logic                           Reset,
  input  logic [3:0]                     PowerDown,
  input  logic [3:0]                     Rate,
  input  logic [pipe_num_of_lanes-1:0]   TxDetectRxLoopback,
  input  logic [pipe_num_of_lanes-1:0]   TxElecIdle,
  input  logic [pipe_num_of_lanes-1:0]   RxPresent,
  output logic [pipe_num_of_lanes-1:0]   PhyStatus,
  output logic [3*pipe_num_of_lanes-1:0] RxStatus,
  output logic [3:0]                     CurPowerDown,
  output logic [3:0]                     CurRate,
  output logic                           Busy
);

  localparam int                NL         = pipe_num_of_lanes;
  localparam logic [CNT_W-1:0]  PD_LAT     = CNT_W'(PD_LATENCY);
  localparam logic [CNT_W-1:0]  RATE_LAT   = CNT_W'(RATE_LATENCY);
  localparam logic [CNT_W-1:0]  DET_LAT    = CNT_W'(DETECT_LATENCY);
  // RESET_WAIT spends its first low cycle loading, so it counts one fewer
  localparam logic [CNT_W-1:0]  RST_LAT_M1 = CNT_W'(RESET_LATENCY - 1);

  phy_state_t       state;
  logic [3:0]       target;
  logic [NL-1:0]    det_mask;
  logic             phy_status_r;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] count;
  logic             at_one;
  logic             at_two;

  logic             pd_req;
  logic             rate_req;
  logic             det_req;
  logic [NL-1:0]    det_req_mask;
  logic [NL-1:0]    det_hits;
  logic [3*NL-1:0]  rx_word;

  // Pending-request decode; only acted on while the FSM is in IDLE
  assign pd_req       = (PowerDown != CurPowerDown);
  assign rate_req     = (Rate != CurRate) && (CurPowerDown == P0);
  assign det_req_mask = TxDetectRxLoopback & TxElecIdle;
  assign det_req      = (CurPowerDown == P1) && (|det_req_mask);

  // With a latency of 1 the result is produced on the accepting edge, so the
  // live request mask is used there; otherwise the latched mask
  assign det_hits = ((state == IDLE) ? det_req_mask : det_mask) & RxPresent;

  // Expand the per-lane hit vector into the 3-bit-per-lane RxStatus word
  always_comb begin
    rx_word = '0;
    for (int i = 0; i < NL; i++) begin
      rx_word[3*i +: 3] = det_hits[i] ? RXSTAT_RX_PRESENT : 3'b000;
    end
  end

  // Counter control mirrors the FSM acceptance priority in IDLE
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      RESET_WAIT: begin
        if (count == '0) begin
          cnt_load = 1'b1;
          cnt_val  = RST_LAT_M1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      IDLE: begin
        if (pd_req) begin
          cnt_load = 1'b1;
          cnt_val  = PD_LAT;
        end else if (rate_req) begin
          cnt_load = 1'b1;
          cnt_val  = RATE_LAT;
        end else if (det_req) begin
          cnt_load = 1'b1;
          cnt_val  = DET_LAT;
        end
      end
      PD_CHANGE, RATE_CHANGE, RX_DETECT: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  pipe_phy_delay_cnt u_delay_cnt (
    .clk      (PCLK),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (count),
    .at_one   (at_one),
    .at_two   (at_two)
  );

  // Responder FSM; pulse outputs are registered one edge ahead (at count 2,
  // or at acceptance when the latency is 1) so they land on count 1
  always_ff @(posedge PCLK) begin
    if (Reset) begin
      state        <= RESET_WAIT;
      phy_status_r <= 1'b1;
      RxStatus     <= '0;
      CurPowerDown <= P1;
      CurRate      <= 4'h0;
      target       <= 4'h0;
      det_mask     <= '0;
    end else begin
      phy_status_r <= 1'b0;
      RxStatus     <= '0;
      case (state)
        RESET_WAIT: begin
          if (((count == '0) && (RESET_LATENCY <= 1)) || (count == CNT_W'(1))) begin
            state <= IDLE;
          end else begin
            phy_status_r <= 1'b1;
          end
        end
        IDLE: begin
          if (pd_req) begin
            target <= PowerDown;
            state  <= PD_CHANGE;
            if (PD_LATENCY == 1) begin
              phy_status_r <= 1'b1;
              CurPowerDown <= PowerDown;
            end
          end else if (rate_req) begin
            target <= Rate;
            state  <= RATE_CHANGE;
            if (RATE_LATENCY == 1) begin
              phy_status_r <= 1'b1;
              CurRate      <= Rate;
            end
          end else if (det_req) begin
            det_mask <= det_req_mask;
            state    <= RX_DETECT;
            if (DETECT_LATENCY == 1) begin
              phy_status_r <= 1'b1;
              RxStatus     <= rx_word;
            end
          end
        end
        PD_CHANGE: begin
          if (at_one) begin
            state <= IDLE;
          end else if (at_two) begin
            phy_status_r <= 1'b1;
            CurPowerDown <= target;
          end
        end
        RATE_CHANGE: begin
          if (at_one) begin
            state <= IDLE;
          end else if (at_two) begin
            phy_status_r <= 1'b1;
            CurRate      <= target;
          end
        end
        RX_DETECT: begin
          if (at_one) begin
            state <= DET_RELEASE;
          end else if (at_two) begin
            phy_status_r <= 1'b1;
            RxStatus     <= rx_word;
          end
        end
        DET_RELEASE: begin
          if (TxDetectRxLoopback == '0) begin
            state <= IDLE;
          end
        end
        default: state <= RESET_WAIT;
      endcase
    end
  end

  assign PhyStatus = {NL{phy_status_r}};
  assign Busy      = (state != IDLE);

endmodule : pipe_phy_cmd_responder
`default_nettype wire

// File: doc/pipe_phy_cmd_responder.md
PIPE_PHY_CMD_RESPONDER -- requirements
Module: pipe_phy_cmd_responder

Interface
REQ-001 SHALL have parameter pipe_num_of_lanes, default 16: number of PIPE lanes served.
REQ-002 SHALL have parameter PD_LATENCY, default 8: PCLK cycles from an accepted PowerDown change to its PhyStatus pulse (legal range 1..65535).
REQ-003 SHALL have parameter RATE_LATENCY, default 16: PCLK cycles from an accepted Rate change to its PhyStatus pulse (legal range 1..65535).
REQ-004 SHALL have parameter DETECT_LATENCY, default 12: PCLK cycles from a receiver-detect request to its result (legal range 1..65535).
REQ-005 SHALL have parameter RESET_LATENCY, default 4: PCLK cycles after Reset deasserts before PhyStatus drops.
REQ-006 PCLK  input  1  sole clock; all logic on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 PowerDown  input  4  MAC power-state request.
REQ-009 Rate  input  4  MAC rate request.
REQ-010 TxDetectRxLoopback  input  pipe_num_of_lanes  per-lane receiver-detect request.
REQ-011 TxElecIdle  input  pipe_num_of_lanes  per-lane transmitter electrical idle.
REQ-012 RxPresent  input  pipe_num_of_lanes  model stimulus: far-end receiver present per lane.
REQ-013 PhyStatus  output  pipe_num_of_lanes  PHY completion/ready indication, all lanes driven identically.
REQ-014 RxStatus  output  3*pipe_num_of_lanes  per-lane status; lane i occupies bits [3i+2:3i].
REQ-015 CurPowerDown  output  4  power state currently in effect.
REQ-016 CurRate  output  4  rate currently in effect.
REQ-017 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement FSM states RESET_WAIT, IDLE, PD_CHANGE, RATE_CHANGE, RX_DETECT, DET_RELEASE.
REQ-019 RESET_WAIT: PhyStatus all-ones; after RESET_LATENCY cycles with Reset low, drive PhyStatus all-zeros and go to IDLE.
REQ-020 IDLE, priority 1: if PowerDown != CurPowerDown, load the counter with PD_LATENCY and go to PD_CHANGE.
REQ-021 IDLE, priority 2: if Rate != CurRate and CurPowerDown == P0, load the counter with RATE_LATENCY and go to RATE_CHANGE; while not in P0, a Rate mismatch stays pending.
REQ-022 IDLE, priority 3: if CurPowerDown == P1 and any lane has TxDetectRxLoopback and TxElecIdle both high, latch the request mask, load the counter with DETECT_LATENCY and go to RX_DETECT.
REQ-023 Latency: PhyStatus SHALL be high for exactly one cycle, the LAT-th cycle after the edge that sampled the triggering input (LAT=1 means the next cycle).
REQ-024 On the PD_CHANGE pulse cycle, CurPowerDown SHALL take the value latched at acceptance and the FSM SHALL return to IDLE.
REQ-025 On the RATE_CHANGE pulse cycle, CurRate SHALL take the value latched at acceptance and the FSM SHALL return to IDLE.
REQ-026 On the RX_DETECT pulse cycle, RxStatus lane i SHALL be 3'b011 if lane i was in the latched mask and RxPresent[i]=1, otherwise 3'b000; RxStatus SHALL be 3'b000 on all other cycles; the FSM then goes to DET_RELEASE.
REQ-027 DET_RELEASE SHALL stay until TxDetectRxLoopback is all-zeros and then go to IDLE, giving one detection per request assertion.
REQ-028 Input changes while Busy SHALL be ignored, not queued; IDLE re-compares them, so the latest value wins.
REQ-029 PowerDown and Rate changing on the same edge: the PowerDown change is serviced first, then the Rate change if the new state is P0.
REQ-030 The counter SHALL be 16 bits, decrement-to-1 and non-wrapping.

Reset
REQ-031 While Reset is high: state RESET_WAIT, PhyStatus all-ones, RxStatus all-zeros, CurPowerDown=P1 (4'h2), CurRate=4'h0, Busy=1, counter and latched mask cleared.
REQ-032 Reset asserted in any state, mid-operation included, SHALL abort that operation with no completion pulse.

Structure
REQ-033 Package pipe_phy_pkg SHALL hold the FSM state enum, power-state constants (P0=4'h0, P0s=4'h1, P1=4'h2, P2=4'h3) and RXSTAT_RX_PRESENT=3'b011.
REQ-034 The load/decrement/done counter SHALL be a sub-module named pipe_phy_delay_cnt.

Verification
REQ-035 Reset released, RESET_LATENCY=4 -> PhyStatus all-ones until the 4th cycle after deassertion, then 0; CurPowerDown=4'h2.
REQ-036 PowerDown 2->0 at edge N, PD_LATENCY=8 -> single PhyStatus pulse at N+8, CurPowerDown=0 the same cycle, Busy cycles N+1..N+8.
REQ-037 In P0, Rate 0->2 plus PowerDown 0->2 on the same edge -> PD pulse first; then no rate pulse while in P1; CurRate stays 0.
REQ-038 In P1, TxDetectRxLoopback=16'h00FF, TxElecIdle all-ones, RxPresent=16'h000F, DETECT_LATENCY=12 -> pulse at +12 with lanes 0-3 RxStatus=3'b011 and all others 3'b000; no second detection until the request deasserts.
REQ-039 Reset asserted mid-RATE_CHANGE -> no rate pulse, CurRate=0, PhyStatus all-ones the next cycle.
REQ-040 Rate changes twice during PD_CHANGE (0->1->3) -> after the PD pulse, a single rate change to 3 is serviced.
